// File: rtl/areg_period_timer.sv
// Periodic / one-shot tick generator driven by the areg control word.
// Reports running/done status to regf and strobes tick_o at each period expiry.
module areg_period_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [31:0]      areg_i,
  output logic             regf_f0_o,
  output logic             regf_f1_o,
  output logic             tick_o,
  output logic [CNT_W-1:0] count_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [31:0]      areg_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             tick_d;

  logic [CNT_W-1:0] period;
  logic             en;
  logic             oneshot;
  logic             period_nz;
  logic             unused_areg;

  assign period    = areg_q[CNT_W-1:0];
  assign en        = areg_q[CNT_W];
  assign oneshot   = areg_q[CNT_W+1];
  assign period_nz = (period != '0);
  // Bits above ONESHOT are ignored by design.
  assign unused_areg = ^areg_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      areg_q <= '0;
    end else begin
      areg_q <= areg_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Disable beats terminal count: a run stopped on its last cycle never ticks.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en && period_nz) begin
          state_d = RUN;
          cnt_d   = period - CNT_W'(1);
        end
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          tick_d = 1'b1;
          if (oneshot) begin
            state_d = DONE;
            cnt_d   = '0;
          end else if (period_nz) begin
            cnt_d = period - CNT_W'(1);
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      DONE: begin
        cnt_d = '0;
        if (!en) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Status and strobe are registered from next-state so they align with state_q.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tick_o    <= 1'b0;
      regf_f0_o <= 1'b0;
      regf_f1_o <= 1'b0;
    end else begin
      tick_o    <= tick_d;
      regf_f0_o <= (state_d == RUN);
      regf_f1_o <= (state_d == DONE);
    end
  end

  assign count_o = cnt_q;

endmodule

// File: tb/tb_areg_period_timer.sv
// Directed bench for areg_period_timer: reset, periodic, one-shot, edge cases
// and mid-run reconfiguration, each against hand-derived edge timings.
module tb_areg_period_timer;

  localparam int CNT_W = 8;
  localparam logic [31:0] EN      = 32'(1) << CNT_W;
  localparam logic [31:0] ONESHOT = 32'(1) << (CNT_W + 1);

  logic             clk_i = 1'b0;
  logic             rst_n_i;
  logic [31:0]      areg_i;
  logic             regf_f0_o;
  logic             regf_f1_o;
  logic             tick_o;
  logic [CNT_W-1:0] count_o;

  int n_checks = 0;
  int n_fail   = 0;

  areg_period_timer #(.CNT_W(CNT_W)) dut (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .areg_i   (areg_i),
    .regf_f0_o(regf_f0_o),
    .regf_f1_o(regf_f1_o),
    .tick_o   (tick_o),
    .count_o  (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic edge_chk(input string tag, input int e, input logic t, input logic f0,
                          input logic f1);
    step();
    check($sformatf("%s_tick_e%0d", tag, e), {31'b0, tick_o}, {31'b0, t});
    check($sformatf("%s_f0_e%0d", tag, e), {31'b0, regf_f0_o}, {31'b0, f0});
    check($sformatf("%s_f1_e%0d", tag, e), {31'b0, regf_f1_o}, {31'b0, f1});
  endtask

  task automatic all_zero(input string tag);
    check({tag, "_tick"}, {31'b0, tick_o}, 32'd0);
    check({tag, "_f0"}, {31'b0, regf_f0_o}, 32'd0);
    check({tag, "_f1"}, {31'b0, regf_f1_o}, 32'd0);
    check({tag, "_count"}, {24'b0, count_o}, 32'd0);
  endtask

  task automatic go_idle(input string tag);
    areg_i = '0;
    repeat (3) step();
    all_zero(tag);
  endtask

  initial begin
    rst_n_i = 1'b0;
    areg_i  = '0;
    #2;
    all_zero("reset_init");
    #10;
    rst_n_i = 1'b1;
    go_idle("idle0");

    // Periodic P=4: ticks at edges 6, 10, 14; next would be 18.
    areg_i = EN | 32'd4;
    for (int e = 1; e <= 16; e++) begin
      edge_chk("per4", e, (e >= 6) && ((e - 6) % 4 == 0), e >= 2, 1'b0);
      if (e == 2) check("per4_count_e2", {24'b0, count_o}, 32'd3);
    end
    // EN dropped so the FSM sees EN=0 exactly on the terminal-count edge.
    areg_i = '0;
    edge_chk("stop_m1", 1, 1'b0, 1'b1, 1'b0);
    check("stop_m1_count", {24'b0, count_o}, 32'd0);
    edge_chk("stop_m2", 2, 1'b0, 1'b0, 1'b0);
    go_idle("idle1");

    // One-shot P=3: single tick at edge 5, then DONE until EN clears.
    areg_i = EN | ONESHOT | 32'd3;
    for (int e = 1; e <= 10; e++) begin
      edge_chk("os3", e, e == 5, (e >= 2) && (e < 5), e >= 5);
    end
    areg_i = '0;
    edge_chk("os_clr", 1, 1'b0, 1'b0, 1'b1);
    edge_chk("os_clr", 2, 1'b0, 1'b0, 1'b0);
    go_idle("idle2");

    // P=0 with EN is an invalid period: stays idle.
    areg_i = EN;
    for (int e = 1; e <= 6; e++) begin
      edge_chk("p0", e, 1'b0, 1'b0, 1'b0);
    end
    go_idle("idle3");

    // P=1 periodic: tick constantly high from edge 3.
    areg_i = EN | 32'd1;
    for (int e = 1; e <= 10; e++) begin
      edge_chk("p1", e, e >= 3, e >= 2, 1'b0);
    end
    go_idle("idle4");

    // Maximum period 2^CNT_W-1: first tick at edge 2 + 255 = 257.
    areg_i = EN | 32'd255;
    for (int e = 1; e <= 260; e++) begin
      edge_chk("pmax", e, e == 257, e >= 2, 1'b0);
      if (e == 2) check("pmax_count_e2", {24'b0, count_o}, 32'd254);
    end
    go_idle("idle5");

    // P 4->2 mid-count: first period still 4 (tick 6), then ticks at 8, 10.
    areg_i = EN | 32'd4;
    for (int e = 1; e <= 11; e++) begin
      edge_chk("p4to2", e, (e == 6) || (e == 8) || (e == 10), e >= 2, 1'b0);
      if (e == 3) areg_i = EN | 32'd2;
    end
    go_idle("idle6");

    // P set to 0 during RUN: final tick at edge 8 then IDLE.
    areg_i = EN | 32'd3;
    for (int e = 1; e <= 12; e++) begin
      edge_chk("p3to0", e, (e == 5) || (e == 8), (e >= 2) && (e < 8), 1'b0);
      if (e == 6) areg_i = EN;
    end
    go_idle("idle7");

    // Asynchronous reset while tick is high, then restart with EN held.
    areg_i = EN | 32'd5;
    for (int e = 1; e <= 7; e++) begin
      edge_chk("pre_rst", e, e == 7, e >= 2, 1'b0);
    end
    #2;
    rst_n_i = 1'b0;
    #1;
    all_zero("rst_async");
    step();
    all_zero("rst_held");
    #3;
    rst_n_i = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      edge_chk("post_rst", e, e == 7, e >= 2, 1'b0);
      if (e == 2) check("post_rst_count_e2", {24'b0, count_o}, 32'd4);
    end
    go_idle("idle8");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
